// File: rtl/axis_multi_adder.sv
// axis_multi_adder: N-channel AXI-Stream join-and-add with one-beat
// per-channel holding registers and an output FIFO.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   s_axis_data   : NUM_CH packed operands, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_valid  : per-channel valid
//   s_axis_ready  : per-channel ready (holding register empty)
//   m_axis_data   : sum at FIFO head, OUT_WIDTH bits
//   m_axis_valid  : FIFO non-empty
//   m_axis_ready  : downstream ready
//   result_count  : results popped since reset (wrapping)
module axis_multi_adder #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int SIGNED     = 0,
  parameter int OUT_DEPTH  = 2,
  localparam int OUT_WIDTH = DATA_WIDTH + $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_data,
  input  logic [NUM_CH-1:0]            s_axis_valid,
  output logic [NUM_CH-1:0]            s_axis_ready,
  output logic [OUT_WIDTH-1:0]         m_axis_data,
  output logic                         m_axis_valid,
  input  logic                         m_axis_ready,
  output logic [31:0]                  result_count
);

  localparam int PW = $clog2(OUT_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = OUT_WIDTH - DATA_WIDTH;

  logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
  logic [DATA_WIDTH-1:0] hold_d [NUM_CH];
  logic [NUM_CH-1:0]     full_q;
  logic [NUM_CH-1:0]     full_d;

  logic [OUT_WIDTH-1:0]  mem_q [OUT_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           rc_q;

  logic [NUM_CH-1:0]     avail;
  logic [DATA_WIDTH-1:0] op;
  logic [OUT_WIDTH-1:0]  ext;
  logic [OUT_WIDTH-1:0]  sum;
  logic                  pop;
  logic                  can_push;
  logic                  fire;

  // Ready comes from registered state only, gated by reset.
  assign s_axis_ready = ~full_q & {NUM_CH{~rst}};
  assign avail        = full_q | (s_axis_valid & s_axis_ready);

  assign m_axis_valid = (cnt_q != '0);
  assign m_axis_data  = mem_q[rd_ptr_q];
  assign result_count = rc_q;

  assign pop      = m_axis_valid && m_axis_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign can_push = (cnt_q != CW'(OUT_DEPTH)) || pop;
  assign fire     = (&avail) && can_push;

  always_comb begin
    sum = '0;
    op  = '0;
    ext = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      op = full_q[i] ? hold_q[i]
                     : s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
      if (SIGNED != 0) ext = {{EW{op[DATA_WIDTH-1]}}, op};
      else             ext = {{EW{1'b0}}, op};
      sum = sum + ext;
    end
  end

  always_comb begin
    full_d = full_q;
    for (int i = 0; i < NUM_CH; i++) hold_d[i] = hold_q[i];
    if (fire) begin
      full_d = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (s_axis_valid[i] && s_axis_ready[i]) begin
          full_d[i] = 1'b1;
          hold_d[i] = s_axis_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
      for (int j = 0; j < OUT_DEPTH; j++) mem_q[j] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rc_q     <= '0;
    end else begin
      full_q <= full_d;
      for (int i = 0; i < NUM_CH; i++) hold_q[i] <= hold_d[i];
      if (fire) begin
        mem_q[wr_ptr_q] <= sum;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        rc_q     <= rc_q + 32'd1;
      end
      if (fire && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!fire && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_axis_multi_adder.sv
// tb_axis_multi_adder: directed bench for axis_multi_adder using three
// instances (2ch unsigned, 4ch unsigned, 3ch signed).
module tb_axis_multi_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] d2;
  logic [1:0]  v2;
  logic [1:0]  r2;
  logic [8:0]  md2;
  logic        mv2;
  logic        mr2;
  logic [31:0] rc2;

  logic [31:0] d4;
  logic [3:0]  v4;
  logic [3:0]  r4;
  logic [9:0]  md4;
  logic        mv4;
  logic        mr4;
  logic [31:0] rc4;

  logic [23:0] ds;
  logic [2:0]  vs;
  logic [2:0]  rs;
  logic [9:0]  mds;
  logic        mvs;
  logic        mrs;
  logic [31:0] rcs;

  axis_multi_adder #(.DATA_WIDTH(8), .NUM_CH(2), .SIGNED(0), .OUT_DEPTH(2)) u2 (
    .clk(clk), .rst(rst),
    .s_axis_data(d2), .s_axis_valid(v2), .s_axis_ready(r2),
    .m_axis_data(md2), .m_axis_valid(mv2), .m_axis_ready(mr2),
    .result_count(rc2)
  );

  axis_multi_adder #(.DATA_WIDTH(8), .NUM_CH(4), .SIGNED(0), .OUT_DEPTH(2)) u4 (
    .clk(clk), .rst(rst),
    .s_axis_data(d4), .s_axis_valid(v4), .s_axis_ready(r4),
    .m_axis_data(md4), .m_axis_valid(mv4), .m_axis_ready(mr4),
    .result_count(rc4)
  );

  axis_multi_adder #(.DATA_WIDTH(8), .NUM_CH(3), .SIGNED(1), .OUT_DEPTH(2)) us (
    .clk(clk), .rst(rst),
    .s_axis_data(ds), .s_axis_valid(vs), .s_axis_ready(rs),
    .m_axis_data(mds), .m_axis_valid(mvs), .m_axis_ready(mrs),
    .result_count(rcs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d2 = '0; v2 = '0; mr2 = 1'b0;
    d4 = '0; v4 = '0; mr4 = 1'b0;
    ds = '0; vs = '0; mrs = 1'b0;
    tick();
    tick();
    vectors++;
    if (r2 !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_ready_low: got %b expected %b", r2, 2'b00);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (r2 !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_ready2: got %b expected %b", r2, 2'b11);
    end
    vectors++;
    if (r4 !== 4'hF || rs !== 3'b111) begin
      miscompares++;
      $display("FAIL rst_ready4s: got %h/%b expected f/111", r4, rs);
    end
    vectors++;
    if (mv2 !== 1'b0 || md2 !== 9'h0) begin
      miscompares++;
      $display("FAIL rst_mout: got v=%b d=%h expected v=0 d=0", mv2, md2);
    end
    vectors++;
    if (rc2 !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_count: got %0d expected 0", rc2);
    end
  endtask

  task automatic test_simultaneous();
    d2 = {8'hFF, 8'hFF};
    v2 = 2'b11;
    tick();
    v2 = 2'b00;
    vectors++;
    if (mv2 !== 1'b1 || md2 !== 9'h1FE) begin
      miscompares++;
      $display("FAIL simul_sum: got v=%b d=%h expected v=1 d=1fe", mv2, md2);
    end
    mr2 = 1'b1;
    tick();
    mr2 = 1'b0;
    vectors++;
    if (mv2 !== 1'b0 || rc2 !== 32'd1) begin
      miscompares++;
      $display("FAIL simul_pop: got v=%b rc=%0d expected v=0 rc=1", mv2, rc2);
    end
  endtask

  task automatic test_staggered();
    d4 = '0;
    d4[0 +: 8] = 8'd10;
    v4 = 4'b0001;
    tick();
    vectors++;
    if (r4 !== 4'b1110) begin
      miscompares++;
      $display("FAIL stag_r0: got %b expected 1110", r4);
    end
    d4 = '0;
    d4[16 +: 8] = 8'd20;
    v4 = 4'b0100;
    tick();
    vectors++;
    if (r4 !== 4'b1010) begin
      miscompares++;
      $display("FAIL stag_r1: got %b expected 1010", r4);
    end
    v4 = 4'b0000;
    tick();
    d4 = '0;
    d4[8 +: 8] = 8'd30;
    v4 = 4'b0010;
    tick();
    vectors++;
    if (r4 !== 4'b1000 || mv4 !== 1'b0) begin
      miscompares++;
      $display("FAIL stag_r3: got r=%b v=%b expected r=1000 v=0", r4, mv4);
    end
    v4 = 4'b0000;
    tick();
    d4 = '0;
    d4[24 +: 8] = 8'd40;
    v4 = 4'b1000;
    tick();
    v4 = 4'b0000;
    vectors++;
    if (mv4 !== 1'b1 || md4 !== 10'd100) begin
      miscompares++;
      $display("FAIL stag_sum: got v=%b d=%0d expected v=1 d=100", mv4, md4);
    end
    vectors++;
    if (r4 !== 4'b1111) begin
      miscompares++;
      $display("FAIL stag_rdy: got %b expected 1111", r4);
    end
    mr4 = 1'b1;
    tick();
    mr4 = 1'b0;
    vectors++;
    if (mv4 !== 1'b0 || rc4 !== 32'd1) begin
      miscompares++;
      $display("FAIL stag_pop: got v=%b rc=%0d expected v=0 rc=1", mv4, rc4);
    end
  endtask

  task automatic test_signed();
    ds = {8'h7F, 8'h80, 8'h80};
    vs = 3'b111;
    tick();
    vs = 3'b000;
    vectors++;
    if (mvs !== 1'b1 || mds !== 10'h37F) begin
      miscompares++;
      $display("FAIL signed_sum: got v=%b d=%h expected v=1 d=37f", mvs, mds);
    end
  endtask

  task automatic test_backpressure();
    int av[4] = '{1, 3, 5, 7};
    int bv[4] = '{2, 4, 6, 8};
    int ev[4] = '{3, 7, 11, 15};
    int ia = 0;
    int ib = 0;
    int np = 0;
    logic [1:0] hs;
    mr2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) begin
        vectors++;
        if (mv2 !== 1'b1 || md2 !== 9'd3 || r2 !== 2'b00) begin
          miscompares++;
          $display("FAIL bp_stall: got v=%b d=%0d r=%b expected v=1 d=3 r=00",
                   mv2, md2, r2);
        end
        mr2 = 1'b1;
      end
      v2[0] = (ia < 4);
      v2[1] = (ib < 4);
      d2[7:0]  = (ia < 4) ? 8'(av[ia]) : 8'h0;
      d2[15:8] = (ib < 4) ? 8'(bv[ib]) : 8'h0;
      #1;
      hs = v2 & r2;
      if (mv2 && mr2) begin
        vectors++;
        if (np >= 4 || md2 !== 9'(ev[np])) begin
          miscompares++;
          $display("FAIL bp_out%0d: got %0d expected %0d", np, md2,
                   (np < 4) ? ev[np] : -1);
        end
        np++;
      end
      tick();
      if (hs[0]) ia++;
      if (hs[1]) ib++;
    end
    v2 = 2'b00;
    mr2 = 1'b0;
    vectors++;
    if (np !== 4 || ia !== 4 || ib !== 4) begin
      miscompares++;
      $display("FAIL bp_counts: got np=%0d ia=%0d ib=%0d expected 4 4 4",
               np, ia, ib);
    end
    vectors++;
    if (rc2 !== 32'd5) begin
      miscompares++;
      $display("FAIL bp_rc: got %0d expected 5", rc2);
    end
  endtask

  task automatic test_back_to_back();
    mr2 = 1'b1;
    for (int j = 0; j < 66; j++) begin
      if (j >= 1 && j <= 64) begin
        vectors++;
        if (mv2 !== 1'b1 || md2 !== 9'(3 * (j - 1) + 1)) begin
          miscompares++;
          $display("FAIL b2b_out%0d: got v=%b d=%0d expected v=1 d=%0d",
                   j - 1, mv2, md2, 3 * (j - 1) + 1);
        end
      end
      if (j < 64) begin
        d2 = {8'(2 * j + 1), 8'(j)};
        v2 = 2'b11;
        vectors++;
        if (r2 !== 2'b11) begin
          miscompares++;
          $display("FAIL b2b_rdy%0d: got %b expected 11", j, r2);
        end
      end else begin
        v2 = 2'b00;
      end
      tick();
    end
    mr2 = 1'b0;
    vectors++;
    if (rc2 !== 32'd69 || mv2 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_rc: got rc=%0d v=%b expected rc=69 v=0", rc2, mv2);
    end
  endtask

  task automatic test_reset_mid();
    mr2 = 1'b0;
    d2 = {8'd1, 8'd9};
    v2 = 2'b11;
    tick();
    d2 = {8'd0, 8'd50};
    v2 = 2'b01;
    tick();
    v2 = 2'b00;
    vectors++;
    if (r2 !== 2'b10 || mv2 !== 1'b1 || md2 !== 9'd10) begin
      miscompares++;
      $display("FAIL mid_pre: got r=%b v=%b d=%0d expected r=10 v=1 d=10",
               r2, mv2, md2);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (r2 !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_rst_rdy: got %b expected 00", r2);
    end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (mv2 !== 1'b0 || rc2 !== 32'd0 || r2 !== 2'b11 || md2 !== 9'd0) begin
      miscompares++;
      $display("FAIL mid_post: got v=%b rc=%0d r=%b d=%0d expected 0 0 11 0",
               mv2, rc2, r2, md2);
    end
    d2 = {8'd5, 8'd4};
    v2 = 2'b11;
    tick();
    v2 = 2'b00;
    vectors++;
    if (mv2 !== 1'b1 || md2 !== 9'd9) begin
      miscompares++;
      $display("FAIL mid_sum: got v=%b d=%0d expected v=1 d=9", mv2, md2);
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_staggered();
    test_signed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
